// File: rtl/demux3_fifo.sv
// demux3_fifo: steers one valid/ready input stream to one of three channels,
// each buffered by its own DEPTH-entry FIFO so consumers stall independently.
module demux3_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [1:0]           in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [3*WIDTH-1:0]   out_data,
  output logic [2:0]           out_valid,
  input  logic [2:0]           out_ready,
  output logic [5:0]           out_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q    [3][DEPTH];
  logic [WIDTH-1:0] mem_d    [3][DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [3];
  logic [PTR_W-1:0] wr_ptr_d [3];
  logic [PTR_W-1:0] rd_ptr_q [3];
  logic [PTR_W-1:0] rd_ptr_d [3];
  logic [CNT_W-1:0] count_q  [3];
  logic [CNT_W-1:0] count_d  [3];

  logic [1:0] dst_s;
  logic [2:0] full_s;
  logic [2:0] push_s;
  logic [2:0] pop_s;

  // Destination decode and per-channel handshake qualification.
  always_comb begin
    case (in_sel)
      2'b00:   dst_s = 2'd0;
      2'b01:   dst_s = 2'd1;
      default: dst_s = 2'd2;
    endcase
    for (int i = 0; i < 3; i++) begin
      full_s[i]    = (count_q[i] == CNT_FULL);
      out_valid[i] = (count_q[i] != {CNT_W{1'b0}});
      pop_s[i]     = out_valid[i] && out_ready[i];
    end
    // Readiness looks only at the addressed channel, never at out_ready.
    in_ready = !full_s[dst_s];
    for (int i = 0; i < 3; i++) begin
      if (in_valid && in_ready && (dst_s == 2'(i))) begin
        push_s[i] = 1'b1;
      end else begin
        push_s[i] = 1'b0;
      end
    end
  end

  // Next-state for storage, pointers and occupancy of each channel.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < 3; i++) begin
      if (push_s[i]) begin
        mem_d[i][wr_ptr_q[i]] = in_data;
        wr_ptr_d[i]           = wr_ptr_q[i] + PTR_W'(1);
      end else begin
        wr_ptr_d[i] = wr_ptr_q[i];
      end
      if (pop_s[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
      end else begin
        rd_ptr_d[i] = rd_ptr_q[i];
      end
      case ({push_s[i], pop_s[i]})
        2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
        2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
        default: count_d[i] = count_q[i];
      endcase
    end
  end

  // State registers; reset clears storage so heads read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          mem_q[i][j] <= {WIDTH{1'b0}};
        end
        wr_ptr_q[i] <= {PTR_W{1'b0}};
        rd_ptr_q[i] <= {PTR_W{1'b0}};
        count_q[i]  <= {CNT_W{1'b0}};
      end
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Heads and low two bits of occupancy, packed channel 0 first.
  always_comb begin
    out_data  = {(3*WIDTH){1'b0}};
    out_count = 6'd0;
    for (int i = 0; i < 3; i++) begin
      out_data[i*WIDTH +: WIDTH] = mem_q[i][rd_ptr_q[i]];
      out_count[i*2 +: 2]        = count_q[i][1:0];
    end
  end

endmodule

// File: tb/tb_demux3_fifo.sv
// Directed self-checking bench for demux3_fifo (WIDTH=8, DEPTH=2).
module tb_demux3_fifo;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] out_data;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready;
  logic [5:0]  out_count;

  int n_cmp;
  int n_bad;

  demux3_fifo #(.WIDTH(8), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] s);
    in_data  = d;
    in_sel   = s;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    step();
    push(8'h42, 2'b01);
    in_sel = 2'b01;
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 3'b000) begin
      n_bad++; $display("FAIL rst_valid got %b exp %b", out_valid, 3'b000);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_ready got %b exp %b", in_ready, 1'b1);
    end
    n_cmp++;
    if (out_count !== 6'd0) begin
      n_bad++; $display("FAIL rst_count got %h exp %h", out_count, 6'd0);
    end
    n_cmp++;
    if (out_data !== 24'd0) begin
      n_bad++; $display("FAIL rst_data got %h exp %h", out_data, 24'd0);
    end
    #1;
    rst_n = 1'b1;
    step();
    step();
    n_cmp++;
    if (out_valid !== 3'b000) begin
      n_bad++; $display("FAIL idle_valid got %b exp %b", out_valid, 3'b000);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL idle_ready got %b exp %b", in_ready, 1'b1);
    end
  endtask

  task automatic test_routing();
    push(8'hA5, 2'b00);
    push(8'h3C, 2'b01);
    push(8'h7E, 2'b10);
    push(8'h11, 2'b11);
    n_cmp++;
    if (out_valid !== 3'b111) begin
      n_bad++; $display("FAIL route_valid got %b exp %b", out_valid, 3'b111);
    end
    n_cmp++;
    if (out_data !== 24'h7E3CA5) begin
      n_bad++; $display("FAIL route_heads got %h exp %h", out_data, 24'h7E3CA5);
    end
    n_cmp++;
    if (out_count !== 6'b10_01_01) begin
      n_bad++; $display("FAIL route_count got %b exp %b", out_count, 6'b10_01_01);
    end
    out_ready = 3'b111;
    step();
    out_ready = 3'b000;
    #1;
    n_cmp++;
    if (out_valid !== 3'b100 || out_data[23:16] !== 8'h11) begin
      n_bad++; $display("FAIL route_pop3 got %b/%h exp %b/%h", out_valid, out_data[23:16], 3'b100, 8'h11);
    end
    out_ready = 3'b100;
    step();
    out_ready = 3'b000;
    #1;
    n_cmp++;
    if (out_valid !== 3'b000) begin
      n_bad++; $display("FAIL route_drain got %b exp %b", out_valid, 3'b000);
    end
  endtask

  task automatic test_full();
    push(8'h01, 2'b01);
    push(8'h02, 2'b01);
    in_sel = 2'b01;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("FAIL full_ready1 got %b exp %b", in_ready, 1'b0);
    end
    in_sel = 2'b00;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL full_ready0 got %b exp %b", in_ready, 1'b1);
    end
    in_sel   = 2'b01;
    in_data  = 8'h03;
    in_valid = 1'b1;
    step();
    n_cmp++;
    if (out_count[3:2] !== 2'd2 || out_data[15:8] !== 8'h01) begin
      n_bad++; $display("FAIL full_hold got %d/%h exp %d/%h", out_count[3:2], out_data[15:8], 2'd2, 8'h01);
    end
    // Pop while full: the push on this same edge must still be refused.
    out_ready = 3'b010;
    step();
    out_ready = 3'b000;
    #1;
    n_cmp++;
    if (out_count[3:2] !== 2'd1 || out_data[15:8] !== 8'h02) begin
      n_bad++; $display("FAIL full_pop got %d/%h exp %d/%h", out_count[3:2], out_data[15:8], 2'd1, 8'h02);
    end
    step();
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if (out_count[3:2] !== 2'd2 || out_data[15:8] !== 8'h02) begin
      n_bad++; $display("FAIL full_accept got %d/%h exp %d/%h", out_count[3:2], out_data[15:8], 2'd2, 8'h02);
    end
    out_ready = 3'b010;
    step();
    n_cmp++;
    if (out_data[15:8] !== 8'h03) begin
      n_bad++; $display("FAIL full_order got %h exp %h", out_data[15:8], 8'h03);
    end
    step();
    out_ready = 3'b000;
    #1;
    n_cmp++;
    if (out_valid !== 3'b000) begin
      n_bad++; $display("FAIL full_drain got %b exp %b", out_valid, 3'b000);
    end
  endtask

  task automatic test_push_pop();
    push(8'h55, 2'b00);
    n_cmp++;
    if (out_count[1:0] !== 2'd1 || out_data[7:0] !== 8'h55) begin
      n_bad++; $display("FAIL pp_pre got %d/%h exp %d/%h", out_count[1:0], out_data[7:0], 2'd1, 8'h55);
    end
    out_ready = 3'b001;
    push(8'h66, 2'b00);
    out_ready = 3'b000;
    #1;
    n_cmp++;
    if (out_count[1:0] !== 2'd1 || out_data[7:0] !== 8'h66) begin
      n_bad++; $display("FAIL pp_same got %d/%h exp %d/%h", out_count[1:0], out_data[7:0], 2'd1, 8'h66);
    end
    out_ready = 3'b001;
    step();
    step();
    out_ready = 3'b000;
    #1;
    n_cmp++;
    if (out_valid !== 3'b000 || out_count !== 6'd0) begin
      n_bad++; $display("FAIL pp_empty got %b/%h exp %b/%h", out_valid, out_count, 3'b000, 6'd0);
    end
  endtask

  task automatic test_wrap();
    out_ready = 3'b100;
    in_sel    = 2'b10;
    in_valid  = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in_data = 8'(k);
      step();
      n_cmp++;
      if (out_data[23:16] !== 8'(k) || out_count[5:4] !== 2'd1) begin
        n_bad++; $display("FAIL wrap_%0d got %h/%d exp %h/%d", k, out_data[23:16], out_count[5:4], 8'(k), 2'd1);
      end
    end
    in_valid = 1'b0;
    step();
    out_ready = 3'b000;
    #1;
    n_cmp++;
    if (out_valid !== 3'b000) begin
      n_bad++; $display("FAIL wrap_end got %b exp %b", out_valid, 3'b000);
    end
  endtask

  task automatic test_mid_reset();
    push(8'hAA, 2'b00);
    push(8'hBB, 2'b00);
    push(8'hCC, 2'b10);
    n_cmp++;
    if (out_count !== 6'b01_00_10) begin
      n_bad++; $display("FAIL mid_pre got %b exp %b", out_count, 6'b01_00_10);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 3'b000 || out_count !== 6'd0 || out_data !== 24'd0) begin
      n_bad++; $display("FAIL mid_rst got %b/%h/%h exp 000/00/000000", out_valid, out_count, out_data);
    end
    #1;
    rst_n = 1'b1;
    step();
    push(8'h99, 2'b00);
    n_cmp++;
    if (out_valid !== 3'b001 || out_data[7:0] !== 8'h99 || out_count !== 6'b00_00_01) begin
      n_bad++; $display("FAIL mid_after got %b/%h/%b exp %b/%h/%b", out_valid, out_data[7:0], out_count, 3'b001, 8'h99, 6'b00_00_01);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_data   = 8'h00;
    in_sel    = 2'b00;
    in_valid  = 1'b0;
    out_ready = 3'b000;
    step();
    step();
    test_reset();
    test_routing();
    test_full();
    test_push_pop();
    test_wrap();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demux3_fifo.md
Name: demux3_fifo

Overview:
- Inverse of the 3:1 select path: one input word with a 2-bit destination select, steered to one of three output channels.
- Each channel has its own small FIFO, so a stalled consumer does not block the other two channels, except when the input word is addressed to that stalled channel.
- Uses valid/ready handshakes on both sides.
- Sits between a single producer (datapath/controller) and three independent consumers.

Parameters:
- WIDTH, 8: data word width in bits.
- DEPTH, 2: entries per channel FIFO. Must be a power of two and ≥ 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active low.
- in_data  input  WIDTH  word to route.
- in_sel  input  2  destination: 00 → ch0, 01 → ch1, 10 or 11 → ch2.
- in_valid  input  1  producer offers in_data/in_sel.
- in_ready  output  1  block accepts this cycle.
- out_data  output  3*WIDTH  packed heads: ch i at bits [i*WIDTH +: WIDTH].
- out_valid  output  3  bit i: ch i head valid.
- out_ready  input  3  bit i: consumer i takes head.
- out_count  output  3*2  packed per-channel occupancy, ch i at [i*2 +: 2]. Saturates the field at DEPTH ≤ 3; wider DEPTH is reported modulo 4.

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n), as already decided.
- Reset (rst_n = 0, takes effect immediately, independent of clk):
  - All FIFOs empty; read/write pointers = 0; counts = 0.
  - out_valid = 3'b000, out_count = 0, out_data = 0 (storage cleared).
  - in_ready reflects the empty state (= 1) while in reset; no push occurs while rst_n = 0.
- Channel decode: dst = 0 if in_sel = 00, 1 if 01, 2 otherwise. Decode is combinational from in_sel.
- in_ready = !full[dst], purely combinational from in_sel and state. It does not depend on in_valid or out_ready, so there is no pass-through when full.
- Push: in_valid && in_ready at the clk edge.
  - Writes in_data into FIFO[dst] at wr_ptr[dst].
  - wr_ptr[dst] increments modulo DEPTH; count[dst] increments.
- Pop, per channel i: out_valid[i] && out_ready[i] at the clk edge.
  - rd_ptr[i] increments modulo DEPTH; count[i] decrements.
- out_valid[i] = (count[i] != 0).
- out_data slice i = mem[i][rd_ptr[i]]. It is stable while out_valid[i] && !out_ready[i].
- Latency: a word pushed at edge N is visible at the output after edge N (1-cycle latency); there is no same-cycle bypass.
- Simultaneous push and pop on the same channel:
  - Count is unchanged; both pointers advance.
  - Allowed whenever not full. When full, the push is refused regardless of the pop.
- Simultaneous pops on multiple channels: all independent, all occur.
- out_ready[i] = 1 while empty has no effect; pointers and count hold.
- in_valid = 1 while the dst channel is full:
  - No state change; the producer must hold in_data/in_sel.
  - The producer may change in_sel to an unblocked channel.
- Ordering: strict FIFO within a channel. There is no ordering relation across channels.
- Reset mid-operation: all stored words are discarded; the state equals the post-reset state.
- Stored words are not altered by pushes to other channels.

Test Plan:
- Reset then idle:
  - Assert rst_n = 0 between clock edges → out_valid = 000 and in_ready = 1 immediately.
  - Release → state unchanged with no input.
- Basic routing:
  - Push A5 with sel 00, 3C with sel 01, 7E with sel 10, 11 with sel 11, out_ready = 000.
  - → out_valid = 111.
  - → ch0 head = A5, ch1 head = 3C, ch2 head = 7E, out_count ch2 = 2.
- Full/backpressure:
  - Push 01, 02 to ch1 with out_ready = 000 → in_ready = 0 for sel 01 and 1 for sel 00.
  - Third push of 03 is held.
  - Pulse out_ready[1] for one cycle → head 01 popped, next head 02.
  - 03 is accepted on the following edge.
- Push+pop same edge:
  - ch0 holding 1 word (55); push 66 while out_ready[0] = 1.
  - → count stays 1, head becomes 66.
- Wrap-around:
  - Stream 16 words 00..0F to ch2 with out_ready[2] = 1 continuously.
  - → output sequence 00..0F in order, no loss/duplication, count ≤ 1 throughout.
- Reset mid-operation:
  - With ch0 = 2 words, ch2 = 1 word, assert rst_n = 0.
  - → out_valid = 000 and counts = 0 immediately.
  - After release, push 99 to ch0 → head 99.
